// File: rtl/caches_pkg.sv
// rtl/caches_pkg.sv - shared types and default constants for the cache/memory arbiter
package caches_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DRD  = 2'd2,
    DWR  = 2'd3
  } arb_state_t;

  typedef logic [31:0] word_t;

  localparam int BURST_LEN_DEF    = 2;
  localparam int STARVE_LIMIT_DEF = 8;

  // True while the memory port is owned by the dcache
  function automatic logic is_dcache_state(input arb_state_t s);
    return (s == DRD) || (s == DWR);
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// rtl/mem_arb_starve_ctr.sv - saturating icache starvation counter with limit compare
module mem_arb_starve_ctr #(
  parameter int LIMIT = 8,
  localparam int CW = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic granted,
  input  logic done,
  output logic hit
);

  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt;

  // Count cycles the icache waits without the grant; a completion or a withdrawn request clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!req || done) begin
      cnt <= '0;
    end else if (!granted && (cnt != LIMIT_C)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign hit = (cnt >= LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - dcache-priority single-port memory arbiter with burst lock; MEM_ARB_PERF_CNT_EN adds perf counters
module mem_arbiter
  import caches_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int BURST_LEN    = BURST_LEN_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              load_done,
  output logic              store_done,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output word_t             icnt,
  output word_t             dcnt,
  output word_t             stall_cnt
`endif
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  arb_state_t    state, state_next;
  logic [BW-1:0] beat_cnt, beat_next;
  logic          starve_hit;
  logic          d_req_ok;
  logic          i_done;
  logic          d_done;

  // Dcache request still matches the op the current burst was granted for (dWEN wins over dREN)
  assign d_req_ok = (state == DWR) ? dWEN : (dREN && !dWEN);

  mem_arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk    (CLK),
    .rst    (RST),
    .req    (iREN),
    .granted(state == IGNT),
    .done   (i_done),
    .hit    (starve_hit)
  );

  // State and beat counter registers; reset aborts any transfer in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_next;
    end
  end

  // Next-state: starving icache first, then dcache write, dcache read, icache; bursts stay locked
  always_comb begin
    state_next = state;
    beat_next  = beat_cnt;
    i_done     = 1'b0;
    d_done     = 1'b0;
    unique case (state)
      IDLE: begin
        beat_next = '0;
        if (starve_hit && iREN) state_next = IGNT;
        else if (dWEN)          state_next = DWR;
        else if (dREN)          state_next = DRD;
        else if (iREN)          state_next = IGNT;
      end
      IGNT: begin
        if (!iREN) begin
          state_next = IDLE;
        end else if (mem_ready) begin
          i_done     = 1'b1;
          state_next = IDLE;
        end
      end
      DRD, DWR: begin
        if (!d_req_ok) begin
          state_next = IDLE;
          beat_next  = '0;
        end else if (mem_ready) begin
          d_done = 1'b1;
          if (beat_cnt < LAST_BEAT) begin
            beat_next = beat_cnt + BW'(1);
          end else begin
            state_next = IDLE;
            beat_next  = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        beat_next  = '0;
      end
    endcase
  end

  // Port outputs decoded from the registered state plus mem_ready; addresses and data pass through
  always_comb begin
    mem_ren    = (state == IGNT) || (state == DRD);
    mem_wen    = (state == DWR);
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state == IGNT) begin
      mem_addr = iaddr;
    end else if (is_dcache_state(state)) begin
      mem_addr  = daddr;
      mem_wdata = dstore;
    end
    iwait      = !i_done;
    iload      = i_done ? mem_rdata : '0;
    dwait      = !d_done;
    load_done  = d_done && (state == DRD);
    store_done = d_done && (state == DWR);
    dload      = (d_done && (state == DRD)) ? mem_rdata : '0;
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic stalled;
  assign stalled = (iREN && !i_done) || ((dREN || dWEN) && !d_done);

  // Free-running wrap-around counters of completed beats and waiting cycles
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      icnt      <= '0;
      dcnt      <= '0;
      stall_cnt <= '0;
    end else begin
      if (i_done)  icnt      <= icnt + 32'd1;
      if (d_done)  dcnt      <= dcnt + 32'd1;
      if (stalled) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter that shares one word-wide memory/bus port between the icache read port and the dcache read/write port.
- Sits between both caches' cif ports (and the dcache's load_done/store_done lines) and the memory/RAM controller.
- Grants the dcache with priority and locks the grant across a full dcache block burst so beats are never interleaved.
- Includes a starvation guard for the icache.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data word width
- BURST_LEN, 2, dcache beats per locked burst (equals cache block size in words)
- STARVE_LIMIT, 8, consecutive icache-waiting cycles before icache is forced ahead of the dcache

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-high
- iREN  in  1  icache read request
- iaddr  in  ADDR_W  icache word address
- iload  out  DATA_W  icache read data
- iwait  out  1  icache stall; low for exactly the completing beat
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request (dREN&dWEN both high is illegal; dWEN wins)
- daddr  in  ADDR_W  dcache word address
- dstore  in  DATA_W  dcache write data
- dload  out  DATA_W  dcache read data
- dwait  out  1  dcache stall; low for exactly the completing beat
- load_done  out  1  pulses with a completing dcache read beat
- store_done  out  1  pulses with a completing dcache write beat
- mem_ren  out  1  memory read strobe
- mem_wen  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completes current access this cycle

Behaviour:
- Reset (RST=1, async): state=IDLE, beat_cnt=0, starve_cnt=0.
  - iwait=1, dwait=1, load_done=0, store_done=0, mem_ren=0, mem_wen=0, mem_addr=0, mem_wdata=0, iload=0, dload=0.
  - Reset mid-access aborts the transfer; no done pulse is issued.
- States: IDLE, IGNT, DRD, DWR.
- IDLE: no memory strobes.
  - If starve_cnt>=STARVE_LIMIT and iREN -> IGNT.
  - Else dWEN -> DWR; else dREN -> DRD; else iREN -> IGNT.
  - Minimum latency is 2 cycles: request seen in IDLE, strobe asserted from the next cycle.
- IGNT: mem_ren=1, mem_addr=iaddr.
  - On mem_ready: iwait=0, iload=mem_rdata, starve_cnt<=0, next state IDLE.
  - If iREN drops before mem_ready: abort to IDLE.
- DRD / DWR: mem_ren (DRD) or mem_wen (DWR) =1, mem_addr=daddr, mem_wdata=dstore; all passed through combinationally.
  - On mem_ready: dwait=0; load_done (DRD) or store_done (DWR) =1; dload=mem_rdata in DRD.
  - If beat_cnt<BURST_LEN-1 and the same request is still asserted next cycle, stay in the state (burst lock; icache cannot interleave) and increment beat_cnt.
  - Else beat_cnt<=0 and go to IDLE.
- Request drop: if the dcache deasserts or switches op (read<->write) mid-burst, go to IDLE and clear beat_cnt; no done pulse.
- Writeback followed by fill (DWR burst then DRD burst): passes through IDLE between bursts. The icache is granted there only if starve_cnt>=STARVE_LIMIT.
- starve_cnt: increments (saturating at STARVE_LIMIT) each cycle iREN=1 and the icache is not granted. Cleared when the icache completes or iREN=0.
- dwait/iwait are high whenever their port is not completing, including while idle.
- load_done/store_done are single-cycle and coincide exactly with dwait=0.
- Outputs other than pass-throughs are decoded from the registered state (Moore-style) plus mem_ready.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, adds outputs icnt, dcnt, stall_cnt (each 32 bits):
  - icnt: completed icache beats
  - dcnt: completed dcache beats
  - stall_cnt: cycles any request waited
- Counters are cleared by RST and wrap at 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package (caches_pkg) holds:
  - arb_state_t enum (IDLE, IGNT, DRD, DWR)
  - word_t
  - BURST_LEN default constant
- One natural sub-module, mem_arb_starve_ctr: the saturating starvation counter with compare output.

Test Plan:
- Both requesters idle: after reset, iwait=dwait=1 and mem_ren=mem_wen=0; done signals stay 0 for 20 cycles.
- Simultaneous iREN and dREN at 0x100, mem_ready after 1 cycle -> DRD granted first; two beats complete (0x100, 0x104) with load_done pulses; iwait=1 throughout; icache is then served.
- dcache read burst with iREN asserted mid-burst -> no icache beat between dcache beats 0 and 1 (burst lock verified).
- STARVE_LIMIT=8 with dREN held continuously -> after 8 icache-waiting cycles the next IDLE grants IGNT; iwait=0 once; starve_cnt returns to 0.
- DWR burst 0x200/0x204 (data 0xDEAD, 0xBEEF) then DRD 0x300 -> mem_wdata matches; store_done pulses twice, then load_done pulses twice.
- RST asserted during DRD beat 1 while mem_ready=0 -> all outputs return to reset values asynchronously; no load_done pulse.
